// File: rtl/spart_rx.sv
// Purpose: 8N1 serial receiver, 16x oversampled by the shared Enable tick; flags data, framing and overrun.
// Latency: RDA/RxD_data/flags update on the clk edge that takes the stop-bit sample (1 clk after that Enable).
// Backpressure: none; an unread byte is overwritten by the next good frame and oerr is raised instead.
//
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   Enable       - one-clk tick at 16x baud
//   RxD          - asynchronous serial input, idle high, LSB first
//   clr_rda      - one-cycle read acknowledge; clears RDA, ferr, oerr
//   RxD_data     - last correctly framed byte
//   RDA          - receive data available
//   ferr, oerr   - sticky framing error / overrun
module spart_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Enable,
  input  logic       RxD,
  input  logic       clr_rda,
  output logic [7:0] RxD_data,
  output logic       RDA,
  output logic       ferr,
  output logic       oerr
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [3:0]  tcnt;
  logic [2:0]  bcnt;
  logic [7:0]  shreg;
  logic [1:0]  sync;
  logic        rxs;
  logic        stop_hit;

  // Synchronizer resets to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], RxD};
    end
  end

  assign rxs = sync[1];

  // Mid-point of the stop bit: the single step where a frame is accepted or rejected.
  assign stop_hit = (state == STOP) && Enable && (tcnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tcnt     <= 4'd0;
      bcnt     <= 3'd0;
      shreg    <= 8'h00;
      RxD_data <= 8'h00;
      RDA      <= 1'b0;
      ferr     <= 1'b0;
      oerr     <= 1'b0;
    end else begin
      // A good frame wins over a coincident clr_rda: the new byte is left
      // pending, and the acknowledge only wipes the older error history.
      if (stop_hit && rxs) begin
        RxD_data <= shreg;
        RDA      <= 1'b1;
        oerr     <= ~clr_rda & (oerr | RDA);
        ferr     <= ~clr_rda & ferr;
      end else if (stop_hit) begin
        ferr <= 1'b1;
        if (clr_rda) begin
          RDA  <= 1'b0;
          oerr <= 1'b0;
        end
      end else if (clr_rda) begin
        RDA  <= 1'b0;
        ferr <= 1'b0;
        oerr <= 1'b0;
      end

      case (state)
        // Start detection runs every clk, not just on ticks, for best edge alignment.
        IDLE: begin
          if (!rxs) begin
            state <= START;
            tcnt  <= 4'd0;
          end
        end
        // Eight ticks after the edge is the middle of the start bit.
        START: begin
          if (Enable) begin
            if (tcnt == 4'd7) begin
              tcnt  <= 4'd0;
              bcnt  <= 3'd0;
              state <= rxs ? IDLE : DATA;
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
        end
        // tcnt wraps 15 -> 0 on its own, so each sample lands one bit later.
        DATA: begin
          if (Enable) begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd15) begin
              shreg <= {rxs, shreg[7:1]};
              if (bcnt == 3'd7) begin
                state <= STOP;
              end else begin
                bcnt <= bcnt + 3'd1;
              end
            end
          end
        end
        // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
        STOP: begin
          if (Enable) begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd15) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Purpose: self-checking bench for spart_rx; frames driven bit-by-bit or by a small transmitter.
// Latency: each received frame is checked on the negedge after the expected stop-sample tick.
// Backpressure: n/a; the bench acknowledges with clr_rda where each scenario requires it.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Enable = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       clr_man = 1'b0;
  logic       clr_auto = 1'b0;
  logic       loop_sel = 1'b0;
  logic       tx_go = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_line;
  logic       clr_rda;
  logic       txd;
  logic [7:0] RxD_data;
  logic       RDA;
  logic       ferr;
  logic       oerr;

  int n_asserts = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic       rda;
    logic       ferr;
    logic       oerr;
    int         tick;  // Enable tick of the stop sample; 0 means not tracked
  } exp_t;

  exp_t exp_q[$];

  spart_rx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Enable   (Enable),
    .RxD      (rx_line),
    .clr_rda  (clr_rda),
    .RxD_data (RxD_data),
    .RDA      (RDA),
    .ferr     (ferr),
    .oerr     (oerr)
  );

  always #5 clk = ~clk;

  assign clr_rda = clr_man | clr_auto;
  assign rx_line = loop_sel ? txd : rxd_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Enable is high at every third rising edge. clr_auto fires exactly at the
  // rising edge whose tick number is clr_tick (the stop sample of a chosen frame).
  int   en_div = 0;
  int   tb_ticks = 0;
  int   clr_tick = -10;
  logic last_en = 1'b0;

  always @(negedge clk) begin
    en_div   = (en_div == 2) ? 0 : en_div + 1;
    Enable   = (en_div == 0);
    clr_auto = Enable && (tb_ticks == clr_tick - 1);
  end

  always @(posedge clk) begin
    if (Enable) tb_ticks <= tb_ticks + 1;
    last_en <= Enable;
  end

  // Minimal 8N1 transmitter on the same Enable ticks, for loopback.
  logic       tx_busy = 1'b0;
  logic [9:0] tx_sh = 10'h3ff;
  int         tx_t = 0;
  int         tx_n = 0;

  always @(posedge clk) begin
    if (tx_go && !tx_busy) begin
      tx_busy <= 1'b1;
      tx_sh   <= {1'b1, tx_data, 1'b0};
      tx_t    <= 0;
      tx_n    <= 0;
    end else if (tx_busy && Enable) begin
      if (tx_t == 15) begin
        tx_t  <= 0;
        tx_sh <= {1'b1, tx_sh[9:1]};
        if (tx_n == 9) tx_busy <= 1'b0;
        else tx_n <= tx_n + 1;
      end else begin
        tx_t <= tx_t + 1;
      end
    end
  end

  assign txd = tx_busy ? tx_sh[0] : 1'b1;

  // Output monitor: any new byte or rising flag is one receive event.
  logic [7:0] p_data = 8'h00;
  logic       p_rda = 1'b0;
  logic       p_ferr = 1'b0;
  logic       p_oerr = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && ((RDA && !p_rda) || (ferr && !p_ferr) || (oerr && !p_oerr) || (RxD_data !== p_data))) begin
      check("event_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rx_data", RxD_data, e.data);
        check("rx_rda", RDA, e.rda);
        check("rx_ferr", ferr, e.ferr);
        check("rx_oerr", oerr, e.oerr);
        if (e.tick > 0) begin
          check("stop_tick", tb_ticks, e.tick);
          check("stop_edge_en", last_en, 1'b1);
        end
      end
    end
    p_data = RxD_data;
    p_rda  = RDA;
    p_ferr = ferr;
    p_oerr = oerr;
  end

  // Called on a negedge; returns on a negedge. The DUT sees the start edge
  // two flops later and enters START on the third rising edge; from there the
  // stop sample is 8 + 8*16 + 16 = 152 Enable ticks away.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len,
                            input logic [7:0] e_data, input logic e_rda, input logic e_ferr,
                            input logic e_oerr, input logic clr_at_stop);
    int t0;
    rxd_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    t0 = tb_ticks;
    exp_q.push_back('{e_data, e_rda, e_ferr, e_oerr, t0 + 152});
    if (clr_at_stop) clr_tick = t0 + 152;
    repeat (46) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (48) @(negedge clk);
    end
    rxd_drv = stop_bit;
    repeat (stop_len) @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_man = 1'b1;
    @(negedge clk);
    clr_man = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_data", RxD_data, 8'h00);
    check("reset_rda", RDA, 1'b0);
    check("reset_ferr", ferr, 1'b0);
    check("reset_oerr", oerr, 1'b0);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Plain frame.
    send_frame(8'h55, 1'b1, 48, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("drain_55");
    pulse_clr();
    check("clr_rda_55", RDA, 1'b0);

    // Loopback through the transmitter.
    loop_sel = 1'b1;
    exp_q.push_back('{8'hAA, 1'b1, 1'b0, 1'b0, 0});
    tx_data = 8'hAA;
    tx_go = 1'b1;
    @(negedge clk);
    tx_go = 1'b0;
    for (int i = 0; i < 700 && (tx_busy || exp_q.size() != 0); i++) @(negedge clk);
    check("loop_tx_done", tx_busy, 1'b0);
    drain("drain_loop");
    loop_sel = 1'b0;
    pulse_clr();
    repeat (20) @(negedge clk);

    // Three-tick low glitch must be rejected as a false start.
    rxd_drv = 1'b0;
    repeat (9) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_rda", RDA, 1'b0);
    check("glitch_ferr", ferr, 1'b0);
    check("glitch_oerr", oerr, 1'b0);

    // Stop bit low; held only past the sample point so the re-armed start
    // detector sees the line high again before its own mid-start check.
    send_frame(8'h3C, 1'b0, 36, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    drain("drain_3c");
    pulse_clr();
    check("ferr_cleared", ferr, 1'b0);
    check("ferr_data_kept", RxD_data, 8'hAA);

    // Back-to-back without acknowledge: overrun.
    send_frame(8'h12, 1'b1, 48, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h34, 1'b1, 48, 8'h34, 1'b1, 1'b0, 1'b1, 1'b0);
    drain("drain_ovr");
    pulse_clr();
    check("ovr_oerr_clr", oerr, 1'b0);
    check("ovr_rda_clr", RDA, 1'b0);

    // Back-to-back with clr_rda on the second stop sample: new byte wins.
    send_frame(8'h12, 1'b1, 48, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h34, 1'b1, 48, 8'h34, 1'b1, 1'b0, 1'b0, 1'b1);
    drain("drain_coinc");
    repeat (10) @(negedge clk);
    check("coinc_rda", RDA, 1'b1);
    check("coinc_oerr", oerr, 1'b0);
    check("coinc_data", RxD_data, 8'h34);
    pulse_clr();

    // Reset in the middle of bit 4 of 0xF0, then a clean 0x0F.
    rxd_drv = 1'b0;
    repeat (48) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd_drv = 1'b0;  // bits 0..3 of 0xF0
      repeat (48) @(negedge clk);
    end
    rxd_drv = 1'b1;    // bit 4 of 0xF0
    repeat (24) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_data", RxD_data, 8'h00);
    check("midrst_rda", RDA, 1'b0);
    #2 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    send_frame(8'h0F, 1'b1, 48, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("drain_0f");
    repeat (10) @(negedge clk);
    check("final_ferr", ferr, 1'b0);
    check("final_oerr", oerr, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
